// File: rtl/fpmul_pipe_param.sv
// Parametrised 4-stage pipelined floating-point multiplier with valid/ready handshake,
// round-to-nearest-even and special-value handling. Define FPMUL_FLAGS_EN to add the flags port.
module fpmul_pipe_param #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [EW+MW:0] a,
  input  logic [EW+MW:0] b,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [EW+MW:0] out,
  output logic           out_valid,
  input  logic           out_ready
`ifdef FPMUL_FLAGS_EN
  ,
  output logic [4:0]     flags
`endif
);

  localparam int W  = EW + MW + 1;
  localparam int MW1 = MW + 1;
  localparam int PW = 2 * MW1;
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] BIAS  = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b1, {(MW - 1){1'b0}}, {EW{1'b1}}, 1'b0};

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW:0]   man;
    logic          zero;
    logic          inf;
    logic          nan;
  } op_t;

  function automatic op_t unpack(input logic [W-1:0] x);
    op_t o;
    o.sign = x[0];
    o.exp  = x[EW:1];
    o.zero = (o.exp == '0);
    o.man  = {!o.zero, x[W-1:EW+1]};
    o.inf  = (&o.exp) && (x[W-1:EW+1] == '0);
    o.nan  = (&o.exp) && (x[W-1:EW+1] != '0);
    return o;
  endfunction

  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  logic s1_valid, s2_valid, s3_valid;
  op_t  s1_a, s1_b;

  logic                 s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [XW-1:0] s2_e;
  logic [PW-1:0]        s2_p;

  logic                 s3_sign, s3_nan, s3_inf, s3_zero;
  logic signed [XW-1:0] s3_e;
  logic [MW-1:0]        s3_frac;

  // S3 combinational: normalise to a leading one at the top, then round to nearest-even.
  logic [PW-1:0]        pn;
  logic signed [XW-1:0] e_norm, e_rnd;
  logic [MW:0]          mant;
  logic [MW+1:0]        sum;
  logic [MW-1:0]        frac_rnd;
  logic                 g, r, st, up;

  // NOTE: every always_comb output gets a default on entry so no path can infer a latch.
  always_comb begin
    pn       = s2_p[PW-1] ? s2_p : (s2_p << 1);
    e_norm   = s2_e + XW'(s2_p[PW-1]);
    mant     = pn[PW-1 -: MW1];
    g        = pn[PW-1-MW1];
    r        = pn[PW-2-MW1];
    st       = |pn[PW-3-MW1:0];
    up       = g & (r | st | mant[0]);
    sum      = {1'b0, mant} + (MW + 2)'(up);
    e_rnd    = e_norm + XW'(sum[MW+1]);
    frac_rnd = sum[MW+1] ? sum[MW:1] : sum[MW-1:0];
  end

  // S4 result selection, highest priority first.
  logic         special, ovf, unf;
  logic [W-1:0] res;
  assign special = s3_nan | s3_inf | s3_zero;
  assign ovf     = !special && (s3_e >= EMAX);
  assign unf     = !special && (s3_e <= EZERO);

  always_comb begin
    res = {s3_frac, s3_e[EW-1:0], s3_sign};
    if (s3_nan)               res = QNAN;
    else if (s3_inf || ovf)   res = {{MW{1'b0}}, {EW{1'b1}}, s3_sign};
    else if (s3_zero || unf)  res = {{(W - 1){1'b0}}, s3_sign};
  end

`ifdef FPMUL_FLAGS_EN
  logic       s3_inexact;
  logic [4:0] flags_d;
  assign flags_d = {s3_nan, ovf, unf,
                    !special && (s3_inexact || ovf || unf),
                    (!s3_nan && !s3_inf && s3_zero) || unf};
`endif

  // Control: valid bits and the output register, cleared by reset and frozen while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
`ifdef FPMUL_FLAGS_EN
      flags     <= '0;
`endif
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) begin
        out   <= res;
`ifdef FPMUL_FLAGS_EN
        flags <= flags_d;
`endif
      end
    end
  end

  // NOTE: datapath registers carry no reset; the stage valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a    <= unpack(a);
      s1_b    <= unpack(b);

      s2_sign <= s1_a.sign ^ s1_b.sign;
      s2_e    <= {2'b00, s1_a.exp} + {2'b00, s1_b.exp} - BIAS;
      s2_p    <= PW'(s1_a.man) * PW'(s1_b.man);
      s2_nan  <= s1_a.nan | s1_b.nan | (s1_a.inf & s1_b.zero) | (s1_a.zero & s1_b.inf);
      s2_inf  <= s1_a.inf | s1_b.inf;
      s2_zero <= s1_a.zero | s1_b.zero;

      s3_sign <= s2_sign;
      s3_e    <= e_rnd;
      s3_frac <= frac_rnd;
      s3_nan  <= s2_nan;
      s3_inf  <= s2_inf;
      s3_zero <= s2_zero;
`ifdef FPMUL_FLAGS_EN
      s3_inexact <= g | r | st;
`endif
    end
  end

endmodule

// File: doc/fpmul_pipe_param.md
Name: fpmul_pipe_param

Overview:
- Parametrised successor to the fixed 32-bit pipelined floating-point multiplier in the ALU32 datapath.
- Generic exponent and mantissa widths, and a valid/ready handshake with full-pipeline stall.
- Adds product normalisation, round-to-nearest-even, special-value handling (zero/inf/NaN), and overflow/underflow saturation.
- Fixed latency of 4 accepted transfers; sits between the operand register file and the ALU result mux.

Parameters:
- EW, 8: exponent field width (bits); bias = 2^(EW-1)-1.
- MW, 23: stored mantissa (fraction) width (bits); hidden 1 is implicit.
- W (localparam), EW+MW+1: total operand width.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  W  operand A.
- b  input  W  operand B.
- in_valid  input  1  operands valid.
- in_ready  output  1  pipeline can accept (transfer on in_valid && in_ready).
- out  output  W  product.
- out_valid  output  1  out holds a result.
- out_ready  input  1  consumer accepts (transfer on out_valid && out_ready).

Behaviour:
- Operand packing, identical to the existing ALU32 format:
  - sign = bit[0].
  - exponent = bits[EW:1].
  - fraction = bits[W-1:EW+1]; fraction LSB at bit EW+1, MSB weight 2^-1 at bit W-1.
- Reset: on a clk edge with reset=1, every stage valid bit clears and out = 0. out_valid = 0 from the following cycle. In-flight operations are discarded.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, no stage register changes, and out and out_valid hold.
  - Bubbles do not collapse; latency is constant.
- Pipeline, 4 stages, each with its own valid bit:
  - S1: register a, b. Unpack sign, exponent, and {1, fraction} (hidden bit 0 when exp=0). Classify each operand: zero (exp=0; subnormals flush to zero), inf (exp all-ones, frac=0), NaN (exp all-ones, frac!=0).
  - S2: sign = sa^sb. Exponent sum e = ea+eb-bias, held in EW+2-bit signed form. Mantissa product p = ma*mb, 2*(MW+1) bits.
  - S3: if p MSB=1, shift right 1 and e+1. Round to nearest, ties to even, using guard/round/sticky bits. If rounding carries out of the mantissa, renormalise and e+1.
  - S4: apply result selection (below), then register out and out_valid.
- With no stall, a result appears 4 cycles after acceptance. One operation per cycle is accepted at full throughput.
- Result selection, in priority order:
  1. Either operand NaN, or inf*zero: canonical NaN = sign 0, exp all-ones, fraction MSB 1, rest 0.
  2. Either operand inf: inf with the xor sign.
  3. Either operand zero: zero with the xor sign.
  4. Final e >= 2^EW-1: overflow, inf with sign.
  5. Final e <= 0: underflow, signed zero (no subnormal output).
  6. Otherwise: normal result.
- Simultaneous events:
  - A new acceptance and an output transfer in the same cycle are legal.
  - reset has priority over in_valid and out_ready.
  - Inputs a and b are ignored when in_valid=0 or in_ready=0.

Optional Feature:
- Macro: FPMUL_FLAGS_EN.
- Defined:
  - Adds output port flags[4:0] = {invalid, overflow, underflow, inexact, zero}, registered alongside out in S4 and valid with out_valid.
  - invalid: NaN produced. overflow/underflow: cases 4/5 above. inexact: any nonzero guard/round/sticky, or saturation. zero: result is ±0.
  - flags reset to 0 and hold during stall.
- Undefined: port absent, no flag logic; all other behaviour identical.

Test Plan (default EW=8, MW=23; hex is the W-bit word):
1. Single ops, out_ready=1: 1.0 (0x000000FE) * 2.0 (0x00000100) -> 0x00000100, 4 cycles after acceptance. 1.5 (0x800000FE) * 1.5 -> 2.25 = 0x20000100. -1.0 (0x000000FF) * 2.0 -> 0x00000101.
2. Rounding: 0x000002FE * 0x000002FE (1+2^-23 squared) -> 0x000004FE; flags.inexact=1 when FPMUL_FLAGS_EN is defined.
3. Specials:
   - inf (0x000001FE) * 0 -> NaN 0x800001FE.
   - inf * -1.0 -> 0x000001FF.
   - 0x800003FE (NaN) * 1.0 -> 0x800001FE.
   - max finite (0xFFFFFFFC) * 2.0 -> overflow 0x000001FE.
   - min normal (0x00000002) * min normal -> 0x00000000.
4. Back-to-back throughput: 8 consecutive in_valid=1 ops, out_ready=1 -> 8 results on 8 consecutive cycles, in order, first at cycle 4.
5. Backpressure: stream ops, drop out_ready for 3 cycles mid-stream -> in_ready=0 those cycles, out held stable, no result lost or duplicated, order preserved.
6. Reset mid-operation: assert reset for 1 cycle with 3 ops in flight -> out_valid=0 and out=0 the next cycle. No stale results appear afterwards; the first new op completes 4 cycles after its acceptance.
